// File: rtl/regfile_writeback_scheduler.sv
// Register-file write-port scheduler: round-robin writeback arbitration, a
// registered write pipeline and a busy-bit scoreboard that stalls RAW/WAW issue.
module regfile_writeback_scheduler #(
    parameter int unsigned REG_WIDTH       = 32,
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned ADDR_WIDTH      = $clog2(NUM_REGS),
    parameter int unsigned NUM_WB          = 2,
    parameter int unsigned REG_ZERO_GROUND = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    input  logic                           issue_rd_we,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    input  logic [ADDR_WIDTH-1:0]          issue_rs0,
    input  logic [ADDR_WIDTH-1:0]          issue_rs1,
    output logic                           issue_stall,
    input  logic [NUM_WB-1:0]              wb_valid,
    output logic [NUM_WB-1:0]              wb_ready,
    input  logic [NUM_WB*ADDR_WIDTH-1:0]   wb_addr,
    input  logic [NUM_WB*REG_WIDTH-1:0]    wb_data,
    output logic                           rf_write_enable,
    output logic [ADDR_WIDTH-1:0]          rf_write_addr,
    output logic [REG_WIDTH-1:0]           rf_write_data,
    output logic [NUM_REGS-1:0]            busy_vector,
    output logic                           wb_orphan_err
);

    localparam int unsigned PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
    localparam logic        GND   = (REG_ZERO_GROUND != 0);

    logic [NUM_REGS-1:0]   busy_q, busy_d, busy_eff;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  data_q, data_d;
    logic                  orph_q, orph_d;

    logic [NUM_WB-1:0]     gnt;
    logic                  found;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [REG_WIDTH-1:0]  sel_data;
    logic                  issue_accept;
    logic                  sel_is_zero;

    // Grounded register 0 always reads as free
    always_comb begin
        busy_eff = busy_q;
        if (GND) begin
            busy_eff[0] = 1'b0;
        end
    end

    assign issue_stall  = issue_valid &&
                          (busy_eff[issue_rs0] || busy_eff[issue_rs1] ||
                           (issue_rd_we && busy_eff[issue_rd]));
    assign issue_accept = issue_valid && !issue_stall;

    // Round-robin search starting at the pointer, ascending with wrap-around
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            for (int unsigned i = 0; i < NUM_WB; i++) begin
                if (!found && wb_valid[i] && (i == ((32'(ptr_q) + k) % NUM_WB))) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    ptr_d  = PTR_W'((i + 1) % NUM_WB);
                end
            end
        end
    end

    assign wb_ready = gnt;
    assign xfer     = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            if (gnt[i]) begin
                sel_addr = wb_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = wb_data[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign sel_is_zero = GND && (sel_addr == '0);

    // Scoreboard and write-pipeline next state; a same-edge set beats the clear
    always_comb begin
        we_d   = xfer && !sel_is_zero;
        addr_d = xfer ? sel_addr : addr_q;
        data_d = xfer ? sel_data : data_q;
        orph_d = orph_q || (xfer && !sel_is_zero && !busy_eff[sel_addr]);
        busy_d = busy_q;
        if (we_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (issue_accept && issue_rd_we && !(GND && (issue_rd == '0))) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (GND) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            ptr_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            orph_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            orph_q <= orph_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_write_addr   = addr_q;
    assign rf_write_data   = data_q;
    assign busy_vector     = busy_q;
    assign wb_orphan_err   = orph_q;

endmodule

// File: tb/tb_regfile_writeback_scheduler.sv
// Bench: two scheduler instances (register 0 normal / grounded) share stimulus
// and are compared every cycle against a behavioural scoreboard model.
module tb_regfile_writeback_scheduler;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              issue_valid, issue_rd_we;
    logic [AW-1:0]     issue_rd, issue_rs0, issue_rs1;
    logic [NW-1:0]     wb_valid;
    logic [NW*AW-1:0]  wb_addr;
    logic [NW*DW-1:0]  wb_data;

    logic              stall  [2];
    logic [NW-1:0]     ready  [2];
    logic              rf_we  [2];
    logic [AW-1:0]     rf_addr[2];
    logic [DW-1:0]     rf_data[2];
    logic [NR-1:0]     busy   [2];
    logic              orph   [2];

    regfile_writeback_scheduler #(.REG_ZERO_GROUND(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd_we(issue_rd_we), .issue_rd(issue_rd),
        .issue_rs0(issue_rs0), .issue_rs1(issue_rs1), .issue_stall(stall[0]),
        .wb_valid(wb_valid), .wb_ready(ready[0]), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_write_enable(rf_we[0]), .rf_write_addr(rf_addr[0]), .rf_write_data(rf_data[0]),
        .busy_vector(busy[0]), .wb_orphan_err(orph[0])
    );

    regfile_writeback_scheduler #(.REG_ZERO_GROUND(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd_we(issue_rd_we), .issue_rd(issue_rd),
        .issue_rs0(issue_rs0), .issue_rs1(issue_rs1), .issue_stall(stall[1]),
        .wb_valid(wb_valid), .wb_ready(ready[1]), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_write_enable(rf_we[1]), .rf_write_addr(rf_addr[1]), .rf_write_data(rf_data[1]),
        .busy_vector(busy[1]), .wb_orphan_err(orph[1])
    );

    // Reference model state (index 1 = grounded register 0)
    logic [NR-1:0] m_busy[2];
    logic          m_we  [2];
    logic          m_orph[2];
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_ptr;
    int            m_gnt;

    int checks = 0;
    int errors = 0;

    logic          pend  [NW];

    function automatic logic mb(int g, logic [AW-1:0] r);
        return (g == 1 && r == 0) ? 1'b0 : m_busy[g][r];
    endfunction

    function automatic logic exp_stall(int g);
        return issue_valid && (mb(g, issue_rs0) || mb(g, issue_rs1) ||
                               (issue_rd_we && mb(g, issue_rd)));
    endfunction

    function automatic int pick();
        for (int k = 0; k < NW; k++) begin
            if (wb_valid[(m_ptr + k) % NW]) return (m_ptr + k) % NW;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int g = 0; g < 2; g++) begin
            m_busy[g] = '0; m_we[g] = 1'b0; m_orph[g] = 1'b0;
        end
        m_addr = '0; m_data = '0; m_ptr = 0;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd_we = 1'b0;
        issue_rd = '0; issue_rs0 = '0; issue_rs1 = '0;
        wb_valid = '0;
    endtask

    task automatic settle();
        logic [NW-1:0] er;
        @(negedge clk); #1;
        m_gnt = pick();
        er = '0;
        if (m_gnt >= 0) er[m_gnt] = 1'b1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("stall%0d", g), 64'(stall[g]),   64'(exp_stall(g)));
            chk($sformatf("ready%0d", g), 64'(ready[g]),   64'(er));
            chk($sformatf("rfwe%0d", g),  64'(rf_we[g]),   64'(m_we[g]));
            chk($sformatf("rfadr%0d", g), 64'(rf_addr[g]), 64'(m_addr));
            chk($sformatf("rfdat%0d", g), 64'(rf_data[g]), 64'(m_data));
            chk($sformatf("busy%0d", g),  64'(busy[g]),    64'(m_busy[g]));
            chk($sformatf("orph%0d", g),  64'(orph[g]),    64'(m_orph[g]));
        end
    endtask

    task automatic tick();
        logic [NR-1:0] nb;
        logic [AW-1:0] a;
        if (rst) begin
            model_clear();
        end else begin
            a = (m_gnt >= 0) ? wb_addr[m_gnt*AW +: AW] : '0;
            for (int g = 0; g < 2; g++) begin
                nb = m_busy[g];
                if (m_we[g]) nb[m_addr] = 1'b0;
                if (issue_valid && !exp_stall(g) && issue_rd_we && !(g == 1 && issue_rd == 0))
                    nb[issue_rd] = 1'b1;
                if (m_gnt >= 0) begin
                    if (!(g == 1 && a == 0) && !mb(g, a)) m_orph[g] = 1'b1;
                    m_we[g] = !(g == 1 && a == 0);
                end else begin
                    m_we[g] = 1'b0;
                end
                m_busy[g] = nb;
            end
            if (m_gnt >= 0) begin
                m_addr = a;
                m_data = wb_data[m_gnt*DW +: DW];
                m_ptr  = (m_gnt + 1) % NW;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic issue(input logic we, input int rd, input int rs0, input int rs1);
        issue_valid = 1'b1; issue_rd_we = we;
        issue_rd = AW'(rd); issue_rs0 = AW'(rs0); issue_rs1 = AW'(rs1);
    endtask

    initial begin
        rst = 1'b1; idle(); wb_addr = '0; wb_data = '0;
        @(posedge clk); #1;
        model_clear();
        rst = 1'b0;

        settle();
        chk("rst_busy", 64'(busy[0]), 64'h0);
        chk("rst_we",   64'(rf_we[0]), 64'h0);
        tick();

        issue(1'b1, 5, 1, 2);
        settle(); chk("issue_rd5_ok", 64'(stall[0]), 64'h0); tick();

        issue(1'b0, 0, 5, 0);
        settle();
        chk("busy5_set", 64'(busy[0]), 64'h20);
        chk("raw_stall", 64'(stall[0]), 64'h1);
        tick();

        wb_valid = 2'b01; wb_addr[AW-1:0] = 5'd5; wb_data[DW-1:0] = 32'hDEADBEEF;
        settle(); chk("wb5_ready", 64'(ready[0]), 64'h1); tick();
        wb_valid = '0;
        settle();
        chk("wb5_we",    64'(rf_we[0]),   64'h1);
        chk("wb5_addr",  64'(rf_addr[0]), 64'h5);
        chk("wb5_data",  64'(rf_data[0]), 64'hDEADBEEF);
        chk("still_stall", 64'(stall[0]), 64'h1);
        tick();
        settle();
        chk("busy5_clr",  64'(busy[0]),  64'h0);
        chk("consumer_go", 64'(stall[0]), 64'h0);
        tick();
        idle();

        rst = 1'b1; cyc(); rst = 1'b0;
        issue(1'b1, 3, 0, 0); cyc();
        issue(1'b1, 4, 0, 0); cyc();
        idle();
        wb_valid = 2'b11;
        wb_addr  = {5'd4, 5'd3};
        wb_data  = {32'h4444_4444, 32'h3333_3333};
        for (int n = 0; n < 4; n++) begin
            settle();
            chk($sformatf("rr_grant%0d", n), 64'(ready[0]), (n % 2 == 0) ? 64'h1 : 64'h2);
            chk($sformatf("rr_onehot%0d", n), 64'($onehot(ready[0])), 64'h1);
            tick();
        end
        wb_valid = '0; cyc(); cyc();

        wb_valid = 2'b01; wb_addr[AW-1:0] = 5'd5; wb_data[DW-1:0] = 32'h5555_0005;
        cyc();
        wb_valid = '0;
        issue(1'b1, 5, 1, 2);
        settle();
        chk("sw_we",    64'(rf_we[0]),   64'h1);
        chk("sw_addr",  64'(rf_addr[0]), 64'h5);
        chk("sw_issue", 64'(stall[0]),   64'h0);
        tick();
        idle();
        settle(); chk("set_wins", 64'(busy[0]), 64'h20); tick();

        rst = 1'b1; cyc(); rst = 1'b0;
        issue(1'b1, 0, 1, 2); cyc();
        issue(1'b0, 0, 0, 0);
        wb_valid = 2'b01; wb_addr[AW-1:0] = 5'd0; wb_data[DW-1:0] = 32'hA5A5_A5A5;
        settle();
        chk("g_busy0",   64'(busy[1]),  64'h0);
        chk("ng_busy0",  64'(busy[0]),  64'h1);
        chk("g_rs0",     64'(stall[1]), 64'h0);
        chk("ng_rs0",    64'(stall[0]), 64'h1);
        chk("g_ready0",  64'(ready[1]), 64'h1);
        tick();
        idle();
        settle();
        chk("g_we0",  64'(rf_we[1]), 64'h0);
        chk("ng_we0", 64'(rf_we[0]), 64'h1);
        tick();
        cyc();

        rst = 1'b1; cyc(); rst = 1'b0;
        wb_valid = 2'b01; wb_addr[AW-1:0] = 5'd9; wb_data[DW-1:0] = 32'h0000_0009;
        settle(); chk("orph_pre", 64'(orph[0]), 64'h0); tick();
        wb_valid = '0;
        settle(); chk("orph_set0", 64'(orph[0]), 64'h1); chk("orph_set1", 64'(orph[1]), 64'h1); tick();
        cyc(); cyc();
        settle(); chk("orph_sticky", 64'(orph[0]), 64'h1); tick();

        rst = 1'b1; issue(1'b1, 7, 0, 0);
        wb_valid = 2'b11; wb_addr = {5'd10, 5'd9};
        cyc();
        rst = 1'b0; idle();
        settle();
        chk("mrst_busy", 64'(busy[0]),    64'h0);
        chk("mrst_we",   64'(rf_we[0]),   64'h0);
        chk("mrst_addr", 64'(rf_addr[0]), 64'h0);
        chk("mrst_data", 64'(rf_data[0]), 64'h0);
        chk("mrst_orph", 64'(orph[0]),    64'h0);
        tick();
        wb_valid = 2'b11;
        settle(); chk("mrst_ptr0", 64'(ready[0]), 64'h1); tick();
        wb_valid = '0; cyc();

        for (int i = 0; i < NW; i++) pend[i] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 63) == 0);
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd_we = 1'($urandom_range(0, 1));
            issue_rd    = AW'($urandom_range(0, 7));
            issue_rs0   = AW'($urandom_range(0, 7));
            issue_rs1   = AW'($urandom_range(0, 7));
            for (int i = 0; i < NW; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    wb_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                    wb_data[i*DW +: DW] = $urandom;
                end
                wb_valid[i] = pend[i];
            end
            settle();
            tick();
            if (m_gnt >= 0) pend[m_gnt] = 1'b0;
        end
        rst = 1'b0; idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
